// File: rtl/bus_master_port.sv
// Master-side bus front end: queues burst commands, requests the arbiter and drives the bus for a whole burst.
// Optional stall-abort logic is compiled in when the BUS_TIMEOUT_EN macro is defined.
module bus_master_port #(
    parameter int AW      = 8,
    parameter int DW      = 8,
    parameter int LENW    = 4,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [AW-1:0]   cmd_addr,
    input  logic            cmd_we,
    input  logic [LENW-1:0] cmd_len,
    output logic            wr_pop,
    input  logic [DW-1:0]   wr_data,
    output logic            rd_valid,
    output logic [DW-1:0]   rd_data,
    output logic            request,
    input  logic            grant,
    output logic            bus_valid,
    output logic [AW-1:0]   bus_addr,
    output logic            bus_we,
    output logic [DW-1:0]   bus_wdata,
    input  logic            bus_ready,
    input  logic [DW-1:0]   bus_rdata,
    output logic            busy,
    output logic            err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = AW + 1 + LENW;

    typedef enum logic [1:0] {IDLE, REQ, XFER, RELEASE} state_t;

    logic [CW-1:0]   r_mem [DEPTH];
    logic [PW:0]     r_wrPtr;
    logic [PW:0]     r_rdPtr;
    state_t          r_state;
    logic [AW-1:0]   r_base;
    logic            r_we;
    logic [LENW-1:0] r_len;
    logic [LENW-1:0] r_beat;
    logic            r_request;
    logic            r_rdValid;
    logic [DW-1:0]   r_rdData;

    logic w_empty;
    logic w_full;
    logic w_push;
    logic w_pop;
    logic w_busValid;
    logic w_beatDone;
    logic w_lastBeat;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign w_empty    = (r_wrPtr == r_rdPtr);
    assign w_full     = (r_wrPtr[PW] != r_rdPtr[PW]) && (r_wrPtr[PW-1:0] == r_rdPtr[PW-1:0]);
    assign w_push     = cmd_valid && !w_full;
    assign w_pop      = (r_state == IDLE) && !w_empty;
    assign w_busValid = (r_state == XFER) && grant;
    assign w_beatDone = w_busValid && bus_ready;
    assign w_lastBeat = (r_beat == r_len);

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wrPtr[PW-1:0]] <= {cmd_addr, cmd_we, cmd_len};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
        end else begin
            if (w_push)
                r_wrPtr <= r_wrPtr + 1'b1;
            if (w_pop)
                r_rdPtr <= r_rdPtr + 1'b1;
        end
    end

`ifdef BUS_TIMEOUT_EN
    localparam int SW = $clog2(TIMEOUT + 1);

    logic [SW-1:0] r_stall;
    logic          r_err;
    logic          w_stallHit;

    assign w_stallHit = w_busValid && !bus_ready && (r_stall == SW'(TIMEOUT - 1));
    assign err        = r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall <= '0;
            r_err   <= 1'b0;
        end else begin
            if (r_state != XFER || w_beatDone)
                r_stall <= '0;
            else if (w_busValid)
                r_stall <= r_stall + 1'b1;
            if (w_stallHit)
                r_err <= 1'b1;
        end
    end
`else
    logic w_stallHit;

    assign w_stallHit = 1'b0;
    assign err        = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_base    <= '0;
            r_we      <= 1'b0;
            r_len     <= '0;
            r_beat    <= '0;
            r_request <= 1'b0;
            r_rdValid <= 1'b0;
            r_rdData  <= '0;
        end else begin
            r_rdValid <= 1'b0;
            if (w_beatDone && !r_we) begin
                r_rdValid <= 1'b1;
                r_rdData  <= bus_rdata;
            end
            case (r_state)
                IDLE: begin
                    if (!w_empty) begin
                        {r_base, r_we, r_len} <= r_mem[r_rdPtr[PW-1:0]];
                        r_request <= 1'b1;
                        r_state   <= REQ;
                    end
                end
                REQ: begin
                    if (grant) begin
                        r_beat  <= '0;
                        r_state <= XFER;
                    end
                end
                XFER: begin
                    if (w_beatDone) begin
                        r_beat <= r_beat + 1'b1;
                        if (w_lastBeat) begin
                            r_request <= 1'b0;
                            r_state   <= RELEASE;
                        end
                    end else if (w_stallHit) begin
                        r_request <= 1'b0;
                        r_state   <= RELEASE;
                    end
                end
                RELEASE: begin
                    // Wait for the arbiter to drop grant so priority rotates before re-requesting.
                    if (!grant)
                        r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign cmd_ready = !w_full;
    assign request   = r_request;
    assign bus_valid = w_busValid;
    assign bus_addr  = r_base + AW'(r_beat);
    assign bus_we    = r_we;
    assign bus_wdata = r_we ? wr_data : '0;
    assign wr_pop    = w_beatDone && r_we;
    assign rd_valid  = r_rdValid;
    assign rd_data   = r_rdData;
    assign busy      = (r_state != IDLE) || !w_empty;

endmodule

// File: tb/tb_bus_master_port.sv
// Directed self-checking bench for bus_master_port; inputs change on the falling edge, outputs are checked 1 ns later.
module tb_bus_master_port;

    logic       clk;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_addr;
    logic       cmd_we;
    logic [3:0] cmd_len;
    logic       wr_pop;
    logic [7:0] wr_data;
    logic       rd_valid;
    logic [7:0] rd_data;
    logic       request;
    logic       grant;
    logic       bus_valid;
    logic [7:0] bus_addr;
    logic       bus_we;
    logic [7:0] bus_wdata;
    logic       bus_ready;
    logic [7:0] bus_rdata;
    logic       busy;
    logic       err;

    int checks = 0;
    int errors = 0;

    bus_master_port #(.AW(8), .DW(8), .LENW(4), .DEPTH(4), .TIMEOUT(15)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_we(cmd_we), .cmd_len(cmd_len),
        .wr_pop(wr_pop), .wr_data(wr_data), .rd_valid(rd_valid), .rd_data(rd_data),
        .request(request), .grant(grant),
        .bus_valid(bus_valid), .bus_addr(bus_addr), .bus_we(bus_we), .bus_wdata(bus_wdata),
        .bus_ready(bus_ready), .bus_rdata(bus_rdata), .busy(busy), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic push_cmd(input logic [7:0] a, input logic w, input logic [3:0] l);
        cmd_valid = 1'b1;
        cmd_addr  = a;
        cmd_we    = w;
        cmd_len   = l;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cmd_valid = 0; cmd_addr = 0; cmd_we = 0; cmd_len = 0;
        wr_data = 0; grant = 0; bus_ready = 0; bus_rdata = 0;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (request !== 1'b0) begin errors++; $display("[TB] FAIL reset_request: got %b expected 0", request); end
        checks++; if (bus_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_bus_valid: got %b expected 0", bus_valid); end
        checks++; if (wr_pop !== 1'b0) begin errors++; $display("[TB] FAIL reset_wr_pop: got %b expected 0", wr_pop); end
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_rd_valid: got %b expected 0", rd_valid); end
        checks++; if (rd_data !== 8'h00) begin errors++; $display("[TB] FAIL reset_rd_data: got %h expected 00", rd_data); end
        checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL reset_err: got %b expected 0", err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_cmd_ready: got %b expected 1", cmd_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_write();
        push_cmd(8'h10, 1'b1, 4'd0);
        #1;
        checks++; if (request !== 1'b0) begin errors++; $display("[TB] FAIL sw_request_early: got %b expected 0", request); end
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL sw_busy: got %b expected 1", busy); end
        @(negedge clk);
        for (int c = 0; c < 2; c++) begin
            #1;
            checks++; if (request !== 1'b1) begin errors++; $display("[TB] FAIL sw_request_wait%0d: got %b expected 1", c, request); end
            checks++; if (bus_valid !== 1'b0) begin errors++; $display("[TB] FAIL sw_valid_nogrant%0d: got %b expected 0", c, bus_valid); end
            @(negedge clk);
        end
        grant = 1'b1;
        #1;
        checks++; if (bus_valid !== 1'b0) begin errors++; $display("[TB] FAIL sw_valid_in_req: got %b expected 0", bus_valid); end
        @(negedge clk);
        bus_ready = 1'b1; wr_data = 8'h5A;
        #1;
        checks++; if (bus_valid !== 1'b1) begin errors++; $display("[TB] FAIL sw_bus_valid: got %b expected 1", bus_valid); end
        checks++; if (bus_addr !== 8'h10) begin errors++; $display("[TB] FAIL sw_bus_addr: got %h expected 10", bus_addr); end
        checks++; if (bus_we !== 1'b1) begin errors++; $display("[TB] FAIL sw_bus_we: got %b expected 1", bus_we); end
        checks++; if (wr_pop !== 1'b1) begin errors++; $display("[TB] FAIL sw_wr_pop: got %b expected 1", wr_pop); end
        checks++; if (bus_wdata !== 8'h5A) begin errors++; $display("[TB] FAIL sw_bus_wdata: got %h expected 5a", bus_wdata); end
        @(negedge clk);
        grant = 1'b0; bus_ready = 1'b0;
        #1;
        checks++; if (request !== 1'b0) begin errors++; $display("[TB] FAIL sw_request_fall: got %b expected 0", request); end
        checks++; if (bus_valid !== 1'b0) begin errors++; $display("[TB] FAIL sw_valid_release: got %b expected 0", bus_valid); end
        checks++; if (wr_pop !== 1'b0) begin errors++; $display("[TB] FAIL sw_wr_pop_release: got %b expected 0", wr_pop); end
        @(negedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL sw_busy_end: got %b expected 0", busy); end
        @(negedge clk);
    endtask

    task automatic test_read_wrap();
        logic [7:0] expAddr;
        logic [7:0] expData;
        push_cmd(8'hFE, 1'b0, 4'd3);
        @(negedge clk);
        grant = 1'b1;
        #1;
        checks++; if (request !== 1'b1) begin errors++; $display("[TB] FAIL rd_request: got %b expected 1", request); end
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            bus_ready = 1'b1;
            bus_rdata = 8'hA0 + 8'(k);
            expAddr   = 8'hFE + 8'(k);
            #1;
            checks++; if (bus_addr !== expAddr) begin errors++; $display("[TB] FAIL rd_addr%0d: got %h expected %h", k, bus_addr, expAddr); end
            checks++; if (bus_valid !== 1'b1 || bus_we !== 1'b0) begin errors++; $display("[TB] FAIL rd_valid_we%0d: got %b%b expected 10", k, bus_valid, bus_we); end
            checks++; if (wr_pop !== 1'b0) begin errors++; $display("[TB] FAIL rd_wr_pop%0d: got %b expected 0", k, wr_pop); end
            checks++; if (request !== 1'b1) begin errors++; $display("[TB] FAIL rd_request%0d: got %b expected 1", k, request); end
            checks++; if (rd_valid !== (k > 0)) begin errors++; $display("[TB] FAIL rd_rd_valid%0d: got %b expected %b", k, rd_valid, (k > 0)); end
            if (k > 0) begin
                expData = 8'hA0 + 8'(k - 1);
                checks++; if (rd_data !== expData) begin errors++; $display("[TB] FAIL rd_data%0d: got %h expected %h", k, rd_data, expData); end
            end
            @(negedge clk);
        end
        grant = 1'b0; bus_ready = 1'b0;
        #1;
        checks++; if (request !== 1'b0) begin errors++; $display("[TB] FAIL rd_request_fall: got %b expected 0", request); end
        checks++; if (rd_valid !== 1'b1 || rd_data !== 8'hA3) begin errors++; $display("[TB] FAIL rd_last_beat: got %b/%h expected 1/a3", rd_valid, rd_data); end
        checks++; if (bus_valid !== 1'b0) begin errors++; $display("[TB] FAIL rd_valid_release: got %b expected 0", bus_valid); end
        @(negedge clk);
        #1;
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("[TB] FAIL rd_valid_pulse: got %b expected 0", rd_valid); end
        @(negedge clk);
    endtask

    task automatic test_fifo_full();
        logic [7:0] expAddr;
        for (int i = 0; i < 5; i++) begin
            cmd_valid = 1'b1; cmd_addr = 8'h20 + 8'(i); cmd_we = 1'b1; cmd_len = 4'd0;
            #1;
            checks++; if (cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL ff_ready_push%0d: got %b expected 1", i, cmd_ready); end
            @(negedge clk);
        end
        cmd_addr = 8'h25;
        #1;
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("[TB] FAIL ff_ready_full: got %b expected 0", cmd_ready); end
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int b = 0; b < 5; b++) begin
            grant = 1'b1;
            #1;
            checks++; if (request !== 1'b1) begin errors++; $display("[TB] FAIL ff_request%0d: got %b expected 1", b, request); end
            checks++; if (cmd_ready !== (b != 0)) begin errors++; $display("[TB] FAIL ff_ready_drain%0d: got %b expected %b", b, cmd_ready, (b != 0)); end
            @(negedge clk);
            bus_ready = 1'b1; wr_data = 8'hC0 + 8'(b);
            expAddr = 8'h20 + 8'(b);
            #1;
            checks++; if (bus_addr !== expAddr || bus_valid !== 1'b1) begin errors++; $display("[TB] FAIL ff_order%0d: got %h/%b expected %h/1", b, bus_addr, bus_valid, expAddr); end
            checks++; if (wr_pop !== 1'b1) begin errors++; $display("[TB] FAIL ff_wr_pop%0d: got %b expected 1", b, wr_pop); end
            @(negedge clk);
            grant = 1'b0; bus_ready = 1'b0;
            #1;
            checks++; if (request !== 1'b0) begin errors++; $display("[TB] FAIL ff_release%0d: got %b expected 0", b, request); end
            @(negedge clk);
            #1;
            checks++; if (busy !== (b < 4)) begin errors++; $display("[TB] FAIL ff_busy%0d: got %b expected %b", b, busy, (b < 4)); end
            @(negedge clk);
        end
    endtask

    task automatic test_stall();
        int pops = 0;
        push_cmd(8'h40, 1'b1, 4'd2);
        @(negedge clk);
        grant = 1'b1;
        @(negedge clk);
        bus_ready = 1'b1; wr_data = 8'h11;
        #1;
        checks++; if (bus_addr !== 8'h40 || wr_pop !== 1'b1) begin errors++; $display("[TB] FAIL st_beat0: got %h/%b expected 40/1", bus_addr, wr_pop); end
        if (wr_pop === 1'b1) pops++;
        @(negedge clk);
        wr_data = 8'h22;
        for (int s = 0; s < 3; s++) begin
            bus_ready = 1'b0;
            #1;
            checks++; if (bus_addr !== 8'h41 || bus_valid !== 1'b1) begin errors++; $display("[TB] FAIL st_hold%0d: got %h/%b expected 41/1", s, bus_addr, bus_valid); end
            checks++; if (wr_pop !== 1'b0) begin errors++; $display("[TB] FAIL st_no_pop%0d: got %b expected 0", s, wr_pop); end
            if (wr_pop === 1'b1) pops++;
            @(negedge clk);
        end
        bus_ready = 1'b1;
        #1;
        checks++; if (bus_addr !== 8'h41 || bus_wdata !== 8'h22 || wr_pop !== 1'b1) begin errors++; $display("[TB] FAIL st_beat1: got %h/%h/%b expected 41/22/1", bus_addr, bus_wdata, wr_pop); end
        if (wr_pop === 1'b1) pops++;
        @(negedge clk);
        wr_data = 8'h33;
        #1;
        checks++; if (bus_addr !== 8'h42 || wr_pop !== 1'b1) begin errors++; $display("[TB] FAIL st_beat2: got %h/%b expected 42/1", bus_addr, wr_pop); end
        if (wr_pop === 1'b1) pops++;
        @(negedge clk);
        #1;
        if (wr_pop === 1'b1) pops++;
        checks++; if (request !== 1'b0 || bus_valid !== 1'b0) begin errors++; $display("[TB] FAIL st_end: got %b/%b expected 0/0", request, bus_valid); end
        checks++; if (pops !== 3) begin errors++; $display("[TB] FAIL st_pop_count: got %0d expected 3", pops); end
        grant = 1'b0; bus_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        push_cmd(8'h60, 1'b1, 4'd0);
        push_cmd(8'h70, 1'b0, 4'd0);
        grant = 1'b1;
        #1;
        checks++; if (request !== 1'b1) begin errors++; $display("[TB] FAIL bb_request0: got %b expected 1", request); end
        @(negedge clk);
        bus_ready = 1'b1;
        #1;
        checks++; if (bus_addr !== 8'h60 || wr_pop !== 1'b1) begin errors++; $display("[TB] FAIL bb_beat0: got %h/%b expected 60/1", bus_addr, wr_pop); end
        @(negedge clk);
        for (int h = 0; h < 2; h++) begin
            #1;
            checks++; if (request !== 1'b0 || bus_valid !== 1'b0) begin errors++; $display("[TB] FAIL bb_hold%0d: got %b/%b expected 0/0", h, request, bus_valid); end
            @(negedge clk);
        end
        grant = 1'b0; bus_ready = 1'b0;
        #1;
        checks++; if (request !== 1'b0) begin errors++; $display("[TB] FAIL bb_grant_drop: got %b expected 0", request); end
        @(negedge clk);
        #1;
        checks++; if (request !== 1'b0 || busy !== 1'b1) begin errors++; $display("[TB] FAIL bb_idle: got %b/%b expected 0/1", request, busy); end
        @(negedge clk);
        grant = 1'b1;
        #1;
        checks++; if (request !== 1'b1) begin errors++; $display("[TB] FAIL bb_rerequest: got %b expected 1", request); end
        @(negedge clk);
        bus_ready = 1'b1; bus_rdata = 8'h99;
        #1;
        checks++; if (bus_addr !== 8'h70 || bus_we !== 1'b0 || bus_valid !== 1'b1) begin errors++; $display("[TB] FAIL bb_beat1: got %h/%b/%b expected 70/0/1", bus_addr, bus_we, bus_valid); end
        @(negedge clk);
        grant = 1'b0; bus_ready = 1'b0;
        #1;
        checks++; if (rd_valid !== 1'b1 || rd_data !== 8'h99) begin errors++; $display("[TB] FAIL bb_rdata: got %b/%h expected 1/99", rd_valid, rd_data); end
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset_mid_burst();
        push_cmd(8'h80, 1'b1, 4'd3);
        push_cmd(8'h90, 1'b1, 4'd0);
        grant = 1'b1;
        @(negedge clk);
        bus_ready = 1'b1;
        #1;
        checks++; if (bus_addr !== 8'h80 || bus_valid !== 1'b1) begin errors++; $display("[TB] FAIL rm_beat0: got %h/%b expected 80/1", bus_addr, bus_valid); end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if (request !== 1'b0 || bus_valid !== 1'b0 || wr_pop !== 1'b0) begin errors++; $display("[TB] FAIL rm_outputs: got %b/%b/%b expected 0/0/0", request, bus_valid, wr_pop); end
        checks++; if (busy !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL rm_fifo: got %b/%b expected 0/1", busy, cmd_ready); end
        checks++; if (rd_data !== 8'h00 || rd_valid !== 1'b0) begin errors++; $display("[TB] FAIL rm_rd: got %h/%b expected 00/0", rd_data, rd_valid); end
        grant = 1'b0; bus_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (request !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL rm_discard: got %b/%b expected 0/0", request, busy); end
        @(negedge clk);
    endtask

`ifdef BUS_TIMEOUT_EN
    task automatic test_timeout();
        push_cmd(8'h30, 1'b0, 4'd1);
        @(negedge clk);
        grant = 1'b1;
        @(negedge clk);
        for (int s = 1; s <= 15; s++) begin
            bus_ready = 1'b0;
            #1;
            checks++; if (bus_valid !== 1'b1 || err !== 1'b0 || request !== 1'b1) begin errors++; $display("[TB] FAIL to_stall%0d: got %b/%b/%b expected 1/0/1", s, bus_valid, err, request); end
            @(negedge clk);
        end
        #1;
        checks++; if (err !== 1'b1 || request !== 1'b0 || bus_valid !== 1'b0 || rd_valid !== 1'b0) begin errors++; $display("[TB] FAIL to_abort: got %b/%b/%b/%b expected 1/0/0/0", err, request, bus_valid, rd_valid); end
        @(negedge clk);
        grant = 1'b0;
        @(negedge clk);
        #1;
        checks++; if (err !== 1'b1 || busy !== 1'b0) begin errors++; $display("[TB] FAIL to_sticky: got %b/%b expected 1/0", err, busy); end
        rst_n = 1'b0;
        #1;
        checks++; if (err !== 1'b0 || request !== 1'b0) begin errors++; $display("[TB] FAIL to_reset: got %b/%b expected 0/0", err, request); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask
`endif

    initial begin
        test_reset();
        test_single_write();
        test_read_wrap();
        test_fifo_full();
        test_stall();
        test_back_to_back();
        test_reset_mid_burst();
`ifdef BUS_TIMEOUT_EN
        test_timeout();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
